// File: rtl/fta_asynch2sync_q.sv
// fta_asynch2sync_q: queued asynchronous-to-synchronous bus adapter.
// Single-cycle upstream request pulses are pushed into a DEPTH-entry queue and
// replayed one at a time to a synchronous slave. The slave cycle is held until
// ack/err/rty; rty is retried up to MAX_RETRY times, silence for TIMEOUT cycles
// yields a synthesised err. Each accepted request returns one response pulse.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_*_i                upstream request (cyc pulse, we, adr, dat, sel, tid)
//   req_full_o, ovf_o      queue full, sticky dropped-request flag
//   resp_*_o               one-cycle response pulse (ack/err/rty, tid, dat)
//   m_*_o                  slave cycle outputs, held stable while active
//   m_ack_i/err_i/rty_i    slave response, m_dat_i slave read data
module fta_asynch2sync_q #(
  parameter int unsigned AWID      = 32,
  parameter int unsigned DWID      = 128,
  parameter int unsigned TIDW      = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_cyc_i,
  input  logic              req_we_i,
  input  logic [AWID-1:0]   req_adr_i,
  input  logic [DWID-1:0]   req_dat_i,
  input  logic [DWID/8-1:0] req_sel_i,
  input  logic [TIDW-1:0]   req_tid_i,
  output logic              req_full_o,
  output logic              ovf_o,
  output logic              resp_ack_o,
  output logic              resp_err_o,
  output logic              resp_rty_o,
  output logic [TIDW-1:0]   resp_tid_o,
  output logic [DWID-1:0]   resp_dat_o,
  output logic              m_cyc_o,
  output logic              m_we_o,
  output logic [AWID-1:0]   m_adr_o,
  output logic [DWID-1:0]   m_dat_o,
  output logic [DWID/8-1:0] m_sel_o,
  output logic [TIDW-1:0]   m_tid_o,
  input  logic              m_ack_i,
  input  logic              m_err_i,
  input  logic              m_rty_i,
  input  logic [DWID-1:0]   m_dat_i
);

  localparam int unsigned SELW = DWID / 8;
  localparam int unsigned EW   = 1 + AWID + DWID + SELW + TIDW;
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} state_t;

  state_t          state, state_d;
  logic [EW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, push, pop;
  logic            nonempty_q;
  logic            any, any_q, resp_edge;
  logic [TW-1:0]   tcnt, tcnt_d;
  logic [RW-1:0]   retry_cnt, retry_d;
  logic            pend, pend_d;
  logic            m_cyc_d;
  logic            ack_d, err_d, rty_d;
  logic [TIDW-1:0] tid_d;
  logic [DWID-1:0] dat_d;

  logic            h_we;
  logic [AWID-1:0] h_adr;
  logic [DWID-1:0] h_dat;
  logic [SELW-1:0] h_sel;
  logic [TIDW-1:0] h_tid;

  assign full       = (count == CW'(DEPTH));
  assign req_full_o = full;
  assign push       = req_cyc_i & ~full;
  assign any        = m_ack_i | m_err_i | m_rty_i;
  assign resp_edge  = any & ~any_q;
  assign {h_we, h_adr, h_dat, h_sel, h_tid} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_we_i, req_adr_i, req_dat_i, req_sel_i, req_tid_i};
  end

  always_comb begin
    state_d = state;
    m_cyc_d = m_cyc_o;
    pop     = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rty_d   = 1'b0;
    tid_d   = '0;
    dat_d   = '0;
    tcnt_d  = tcnt;
    retry_d = retry_cnt;
    pend_d  = pend;
    case (state)
      IDLE: begin
        tcnt_d = '0;
        // nonempty_q delays issue of a freshly pushed entry by one cycle
        if (nonempty_q && (count != '0)) begin
          pop     = 1'b1;
          m_cyc_d = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (resp_edge) begin
          m_cyc_d = 1'b0;
          state_d = RELEASE;
          if (m_err_i || m_ack_i) begin
            err_d   = m_err_i;
            ack_d   = ~m_err_i;
            tid_d   = m_tid_o;
            dat_d   = m_dat_i;
            retry_d = '0;
          end else if (retry_cnt < RW'(MAX_RETRY)) begin
            retry_d = retry_cnt + 1'b1;
            pend_d  = 1'b1;
          end else begin
            rty_d   = 1'b1;
            tid_d   = m_tid_o;
            dat_d   = m_dat_i;
            retry_d = '0;
          end
        end else if (tcnt == TW'(TIMEOUT)) begin
          err_d   = 1'b1;
          tid_d   = m_tid_o;
          m_cyc_d = 1'b0;
          retry_d = '0;
          state_d = RELEASE;
        end else begin
          tcnt_d = tcnt + 1'b1;
        end
      end
      RELEASE: begin
        if (!any) begin
          if (pend) begin
            pend_d  = 1'b0;
            m_cyc_d = 1'b1;
            tcnt_d  = '0;
            state_d = ACTIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ovf_o      <= 1'b0;
      nonempty_q <= 1'b0;
      any_q      <= 1'b0;
      tcnt       <= '0;
      retry_cnt  <= '0;
      pend       <= 1'b0;
      m_cyc_o    <= 1'b0;
      m_we_o     <= 1'b0;
      m_adr_o    <= '0;
      m_dat_o    <= '0;
      m_sel_o    <= '0;
      m_tid_o    <= '0;
      resp_ack_o <= 1'b0;
      resp_err_o <= 1'b0;
      resp_rty_o <= 1'b0;
      resp_tid_o <= '0;
      resp_dat_o <= '0;
    end else begin
      state      <= state_d;
      nonempty_q <= (count != '0);
      any_q      <= any;
      tcnt       <= tcnt_d;
      retry_cnt  <= retry_d;
      pend       <= pend_d;
      m_cyc_o    <= m_cyc_d;
      resp_ack_o <= ack_d;
      resp_err_o <= err_d;
      resp_rty_o <= rty_d;
      resp_tid_o <= tid_d;
      resp_dat_o <= dat_d;
      if (req_cyc_i && full) ovf_o <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        m_we_o  <= h_we;
        m_adr_o <= h_adr;
        m_dat_o <= h_dat;
        m_sel_o <= h_sel;
        m_tid_o <= h_tid;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fta_asynch2sync_q.sv
module tb_fta_asynch2sync_q;

  localparam int unsigned AWID = 32;
  localparam int unsigned DWID = 128;
  localparam int unsigned TIDW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_cyc_i = 1'b0, req_we_i = 1'b0;
  logic [AWID-1:0]   req_adr_i = '0;
  logic [DWID-1:0]   req_dat_i = '0;
  logic [DWID/8-1:0] req_sel_i = '0;
  logic [TIDW-1:0]   req_tid_i = '0;
  logic              req_full_o, ovf_o, resp_ack_o, resp_err_o, resp_rty_o;
  logic [TIDW-1:0]   resp_tid_o, m_tid_o;
  logic [DWID-1:0]   resp_dat_o, m_dat_o;
  logic              m_cyc_o, m_we_o;
  logic [AWID-1:0]   m_adr_o;
  logic [DWID/8-1:0] m_sel_o;
  logic              m_ack_i = 1'b0, m_err_i = 1'b0, m_rty_i = 1'b0;
  logic [DWID-1:0]   m_dat_i = '0;

  fta_asynch2sync_q #(.AWID(AWID), .DWID(DWID), .TIDW(TIDW), .DEPTH(4),
                      .MAX_RETRY(3), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_cyc_i(req_cyc_i), .req_we_i(req_we_i), .req_adr_i(req_adr_i),
    .req_dat_i(req_dat_i), .req_sel_i(req_sel_i), .req_tid_i(req_tid_i),
    .req_full_o(req_full_o), .ovf_o(ovf_o),
    .resp_ack_o(resp_ack_o), .resp_err_o(resp_err_o), .resp_rty_o(resp_rty_o),
    .resp_tid_o(resp_tid_o), .resp_dat_o(resp_dat_o),
    .m_cyc_o(m_cyc_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
    .m_sel_o(m_sel_o), .m_tid_o(m_tid_o),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_rty_i(m_rty_i), .m_dat_i(m_dat_i)
  );

  always #5 clk = ~clk;

  // expected response: f = {err, ack, rty}
  typedef struct {
    logic [2:0]   f;
    logic [7:0]   tid;
    logic [127:0] dat;
    bit           cd;
  } exp_t;

  exp_t sb[$];
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned pulses = 0;
  int unsigned rises = 0;
  logic cyc_prev = 1'b0;

  localparam logic [2:0] F_ERR = 3'b100;
  localparam logic [2:0] F_ACK = 3'b010;
  localparam logic [2:0] F_RTY = 3'b001;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] tid, input logic [31:0] adr, input bit expect_it,
                      input logic [2:0] f, input logic [127:0] dat, input bit cd);
    exp_t e;
    req_cyc_i = 1'b1;
    req_we_i  = adr[0];
    req_adr_i = adr;
    req_dat_i = {96'h0, adr};
    req_sel_i = '1;
    req_tid_i = tid;
    if (expect_it) begin
      e.f = f; e.tid = tid; e.dat = dat; e.cd = cd;
      sb.push_back(e);
    end
    tick();
    req_cyc_i = 1'b0;
  endtask

  task automatic respond(input logic [2:0] f, input logic [127:0] d, input int unsigned hold);
    {m_err_i, m_ack_i, m_rty_i} = f;
    m_dat_i = d;
    repeat (hold) tick();
    {m_err_i, m_ack_i, m_rty_i} = 3'b000;
  endtask

  task automatic wait_cyc(input string tag);
    int unsigned n = 0;
    while (m_cyc_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 128'(m_cyc_o), 128'(1));
  endtask

  // response monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (m_cyc_o && !cyc_prev) rises++;
    cyc_prev = m_cyc_o;
    if (resp_ack_o || resp_err_o || resp_rty_o) begin
      pulses++;
      chk("pulse_expected", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("resp_flags", 128'({resp_err_o, resp_ack_o, resp_rty_o}), 128'(e.f));
        chk("resp_tid", 128'(resp_tid_o), 128'(e.tid));
        if (e.cd) chk("resp_dat", resp_dat_o, e.dat);
      end
    end
  end

  initial begin
    int unsigned r0, p0;
    // reset
    tick(); tick();
    chk("rst_m_cyc", 128'(m_cyc_o), 128'(0));
    chk("rst_resp", 128'({resp_ack_o, resp_err_o, resp_rty_o}), 128'(0));
    chk("rst_full_ovf", 128'({req_full_o, ovf_o}), 128'(0));
    chk("rst_m_adr", 128'(m_adr_o), 128'(0));
    rst_n = 1'b1;
    tick();

    // single read: issue 2 edges after sampling, ack after 3 cycles
    push(8'd5, 32'h100, 1'b1, F_ACK, 128'hAB, 1'b1);
    chk("rd_cyc_e0", 128'(m_cyc_o), 128'(0));
    tick();
    chk("rd_cyc_e1", 128'(m_cyc_o), 128'(0));
    tick();
    chk("rd_cyc_e2", 128'(m_cyc_o), 128'(1));
    chk("rd_adr", 128'(m_adr_o), 128'(32'h100));
    chk("rd_tid", 128'(m_tid_o), 128'(5));
    repeat (3) tick();
    chk("rd_cyc_held", 128'(m_cyc_o), 128'(1));
    respond(F_ACK, 128'hAB, 1);
    chk("rd_ack_pulse", 128'(resp_ack_o), 128'(1));
    chk("rd_cyc_drop", 128'(m_cyc_o), 128'(0));
    tick();
    chk("rd_ack_once", 128'(resp_ack_o), 128'(0));
    tick(); tick();

    // queue fill behind a stalled transaction
    push(8'hD0, 32'h2000, 1'b1, F_ACK, 128'h11, 1'b1);
    wait_cyc("fill_dummy_issue");
    for (int i = 0; i < 5; i++) begin
      push(8'(i), 32'h1000 + 32'(i * 16), (i < 4), F_ACK, 128'h200 + 128'(i), 1'b1);
      if (i == 2) chk("fill_not_full", 128'(req_full_o), 128'(0));
      if (i == 3) chk("fill_full", 128'(req_full_o), 128'(1));
      if (i == 3) chk("fill_no_ovf", 128'(ovf_o), 128'(0));
    end
    chk("fill_ovf", 128'(ovf_o), 128'(1));
    respond(F_ACK, 128'h11, 1);
    // back-to-back: next cycle rises 2 edges after the pulse
    chk("b2b_e0", 128'(m_cyc_o), 128'(0));
    tick();
    chk("b2b_e1", 128'(m_cyc_o), 128'(0));
    tick();
    chk("b2b_e2", 128'(m_cyc_o), 128'(1));
    chk("fill_drain_full", 128'(req_full_o), 128'(0));
    for (int i = 0; i < 4; i++) begin
      wait_cyc("fill_issue");
      chk("fill_order_tid", 128'(m_tid_o), 128'(i));
      chk("fill_order_adr", 128'(m_adr_o), 128'(32'h1000 + 32'(i * 16)));
      tick();
      respond(F_ACK, 128'h200 + 128'(i), 1);
    end
    tick(); tick();
    chk("fill_sb_empty", 128'(sb.size()), 128'(0));
    chk("ovf_sticky", 128'(ovf_o), 128'(1));

    // retry twice then ack
    r0 = rises;
    push(8'h33, 32'h300, 1'b1, F_ACK, 128'h77, 1'b1);
    for (int i = 0; i < 3; i++) begin
      wait_cyc("retry_issue");
      tick();
      respond((i < 2) ? F_RTY : F_ACK, 128'h77, 1);
    end
    tick(); tick();
    chk("retry_cycles", 128'(rises - r0), 128'(3));

    // retry exhaustion: 4 slave cycles then rty upstream
    r0 = rises;
    push(8'h44, 32'h400, 1'b1, F_RTY, 128'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_cyc("exh_issue");
      respond(F_RTY, 128'h0, 1);
    end
    repeat (4) tick();
    chk("exh_cycles", 128'(rises - r0), 128'(4));
    chk("exh_idle", 128'(m_cyc_o), 128'(0));
    chk("exh_sb_empty", 128'(sb.size()), 128'(0));

    // timeout with silent slave; next queued request follows
    m_dat_i = 128'hDEAD;
    push(8'h55, 32'h500, 1'b1, F_ERR, 128'h0, 1'b1);
    push(8'h56, 32'h504, 1'b1, F_ACK, 128'h99, 1'b1);
    wait_cyc("to_issue");
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) chk("to_not_yet", 128'(resp_err_o), 128'(0));
      if (k == 16) chk("to_err_pulse", 128'(resp_err_o), 128'(1));
    end
    wait_cyc("to_next_issue");
    chk("to_next_tid", 128'(m_tid_o), 128'(8'h56));
    respond(F_ACK, 128'h99, 1);
    tick(); tick();

    // held ack produces a single pulse
    p0 = pulses;
    push(8'h66, 32'h600, 1'b1, F_ACK, 128'h5A, 1'b1);
    wait_cyc("held_issue");
    respond(F_ACK, 128'h5A, 5);
    repeat (4) tick();
    chk("held_one_pulse", 128'(pulses - p0), 128'(1));

    // reset while active with queue full and overflow set
    for (int i = 0; i < 6; i++) push(8'h70 + 8'(i), 32'h700, 1'b0, F_ACK, 128'h0, 1'b0);
    chk("mid_active", 128'(m_cyc_o), 128'(1));
    chk("mid_ovf", 128'(ovf_o), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", 128'(m_cyc_o), 128'(0));
    chk("mid_rst_flags", 128'({req_full_o, ovf_o}), 128'(0));
    chk("mid_rst_m", 128'({m_adr_o, m_tid_o, m_we_o}), 128'(0));
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("mid_queue_empty", 128'(m_cyc_o), 128'(0));
    push(8'h77, 32'h800, 1'b1, F_ACK, 128'hC3, 1'b1);
    wait_cyc("post_rst_issue");
    respond(F_ACK, 128'hC3, 1);
    tick(); tick();
    chk("final_sb_empty", 128'(sb.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
